// File: rtl/cipher_uart_tx.sv
// cipher_uart_tx: serializer for the OTP encryptor output.
// Buffers {pad index, ciphertext byte} pairs in a small FIFO. Each pair is sent
// on a UART line as two back-to-back 8N1 frames: a header byte 8'hA0 | index,
// then the ciphertext byte. Consecutive entries follow with no idle bits.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (abandons any frame, flushes FIFO)
//   in_valid   upstream offers {in_index, in_data}
//   in_ready   FIFO has room and reset has been released
//   in_data    ciphertext byte
//   in_index   pad index used for in_data
//   tx         registered UART line, idle high
//   busy       frame in progress or FIFO non-empty
//   fifo_count entries currently buffered
module cipher_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  input  logic [2:0]                    in_index,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int              PW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [15:0]     BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        state_q, state_d;
  logic [10:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          pay_q, pay_d;        // 0: header frame, 1: payload frame
  logic [7:0]    cur_q, cur_d;        // byte currently on the wire
  logic [7:0]    held_q, held_d;      // payload waiting behind its header
  logic          tx_q, tx_d;
  logic          up_q, up_d;          // low on the cycle after any reset edge
  logic          push, pop, bit_end;
  logic [10:0]   head;

  assign head       = mem_q[rd_ptr_q];
  assign bit_end    = (baud_q == BAUD_MAX);
  assign in_ready   = up_q && (count_q < DEPTH_C);
  assign push       = in_valid && in_ready;
  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;

  // State register (plus datapath flops)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      pay_q    <= 1'b0;
      cur_q    <= '0;
      held_q   <= '0;
      tx_q     <= 1'b1;
      up_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      pay_q    <= pay_d;
      cur_q    <= cur_d;
      held_q   <= held_d;
      tx_q     <= tx_d;
      up_q     <= up_d;
    end
  end

  // FIFO storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= {in_index, in_data};
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:  if (bit_end && bit_q == 3'd7) state_d = S_STOP;
      S_STOP: begin
        if (bit_end) state_d = (pay_q && count_q == '0) ? S_IDLE : S_START;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic. tx_d is the line level for the cycle after the
  // edge, so every bit boundary is decided here one cycle ahead.
  always_comb begin
    pop    = 1'b0;
    up_d   = 1'b1;
    baud_d = (state_q == S_IDLE || bit_end) ? '0 : baud_q + 16'd1;
    bit_d  = bit_q;
    pay_d  = pay_q;
    cur_d  = cur_q;
    held_d = held_q;
    tx_d   = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop    = 1'b1;
          cur_d  = {5'b10100, head[10:8]};
          held_d = head[7:0];
          pay_d  = 1'b0;
          tx_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_d = 3'd0;
          tx_d  = cur_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_q[bit_q + 3'd1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!pay_q) begin
            pay_d = 1'b1;
            cur_d = held_q;
            tx_d  = 1'b0;
          end else if (count_q != '0) begin
            // next entry's header starts straight after this stop bit
            pop    = 1'b1;
            cur_d  = {5'b10100, head[10:8]};
            held_d = head[7:0];
            pay_d  = 1'b0;
            tx_d   = 1'b0;
          end else begin
            tx_d = 1'b1;
          end
        end
      end
      default: tx_d = 1'b1;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end
endmodule

// File: tb/tb_cipher_uart_tx.sv
module tb_cipher_uart_tx;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid4, in_valid2;
  logic       in_ready4, in_ready2;
  logic [7:0] in_data;
  logic [2:0] in_index;
  logic       tx4, tx2, busy4, busy2;
  logic [2:0] count4, count2;

  int n_run = 0, n_fail = 0;
  int cyc = 0;

  logic [7:0] sd [32];
  logic [2:0] si [32];
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] d;
    logic [2:0] ix;
    logic [7:0] hdr;
    logic [7:0] pay;
  } vec_t;
  vec_t vt [5];

  cipher_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data), .in_index(in_index), .tx(tx4), .busy(busy4),
    .fifo_count(count4));

  cipher_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data), .in_index(in_index), .tx(tx2), .busy(busy2),
    .fifo_count(count2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic txs(input bit s2);
    return s2 ? tx2 : tx4;
  endfunction
  function automatic logic rdy(input bit s2);
    return s2 ? in_ready2 : in_ready4;
  endfunction
  function automatic logic vld(input bit s2);
    return s2 ? in_valid2 : in_valid4;
  endfunction
  task automatic set_valid(input bit s2, input logic v);
    if (s2) in_valid2 = v; else in_valid4 = v;
  endtask

  // Receiver model: find the start bit, sample mid-bit, return the byte.
  task automatic rx_frame(input bit s2, output logic [7:0] b, output bit ok, output int t0);
    int cpb = s2 ? 2 : 4;
    int w = 0;
    b = '0; ok = 1'b0; t0 = 0;
    while (txs(s2) !== 1'b0 && w < 3000) begin step(); w++; end
    if (w >= 3000) return;
    t0 = cyc;
    repeat (cpb / 2) step();
    ok = (txs(s2) === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) step();
      b[i] = txs(s2);
    end
    repeat (cpb) step();
    ok = ok && (txs(s2) === 1'b1);
  endtask

  // Single push from idle, then cycle-exact check of the 20-bit line pattern.
  task automatic send_exact(input string nm, input logic [7:0] d, input logic [2:0] ix,
                            input logic [7:0] hdr, input logic [7:0] pay);
    logic [19:0] fb;
    fb = {1'b1, pay, 1'b0, 1'b1, hdr, 1'b0};
    in_data = d; in_index = ix; in_valid4 = 1'b1;
    chk({nm, " ready"}, in_ready4, 1);
    step();
    in_valid4 = 1'b0;
    chk({nm, " count after push"}, count4, 1);
    chk({nm, " busy after push"}, busy4, 1);
    step();
    chk({nm, " count after pop"}, count4, 0);
    for (int j = 0; j < 80; j++) begin
      chk($sformatf("%s tx cycle %0d", nm, j), tx4, fb[j / 4]);
      if (j == 79) chk({nm, " busy last cycle"}, busy4, 1);
      step();
    end
    chk({nm, " busy at pop+80"}, busy4, 0);
    chk({nm, " tx idle"}, tx4, 1);
  endtask

  // Randomized stream against the scoreboard: pusher and receiver run together.
  task automatic run_stream(input string nm, input bit s2, input int n, input bit gaps);
    int cpb = s2 ? 2 : 4;
    exp_q.delete();
    for (int j = 0; j < n; j++) begin
      sd[j] = 8'($urandom);
      si[j] = 3'($urandom);
    end
    fork
      begin
        int j = 0;
        int g = 0;
        bit pushed;
        while (j < n && g < 5000) begin
          if (gaps && $urandom_range(0, 2) == 0) set_valid(s2, 1'b0);
          else begin
            in_data = sd[j]; in_index = si[j]; set_valid(s2, 1'b1);
          end
          pushed = vld(s2) && rdy(s2);
          step(); g++;
          if (pushed) begin
            exp_q.push_back(8'hA0 | {5'd0, si[j]});
            exp_q.push_back(sd[j]);
            j++;
          end
        end
        set_valid(s2, 1'b0);
        chk({nm, " all entries accepted"}, j, n);
      end
      begin
        int t0, tp;
        logic [7:0] b;
        bit ok;
        tp = 0;
        for (int f = 0; f < 2 * n; f++) begin
          rx_frame(s2, b, ok, t0);
          chk($sformatf("%s framing %0d", nm, f), ok, 1);
          if (exp_q.size() == 0) chk($sformatf("%s unexpected frame %0d", nm, f), 1, 0);
          else chk($sformatf("%s byte %0d", nm, f), b, exp_q.pop_front());
          if (!gaps && f > 0) chk($sformatf("%s spacing %0d", nm, f), t0 - tp, 10 * cpb);
          tp = t0;
        end
      end
    join
    repeat (2 * cpb) step();
    chk({nm, " busy at end"}, s2 ? busy2 : busy4, 0);
    chk({nm, " scoreboard drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int p;
    vt[0] = '{8'h5A, 3'd0, 8'hA0, 8'h5A};
    vt[1] = '{8'hC3, 3'd7, 8'hA7, 8'hC3};
    vt[2] = '{8'h00, 3'd1, 8'hA1, 8'h00};
    vt[3] = '{8'hFF, 3'd2, 8'hA2, 8'hFF};
    vt[4] = '{8'h11, 3'd4, 8'hA4, 8'h11};

    rst_n = 1'b0; in_valid4 = 1'b0; in_valid2 = 1'b0; in_data = '0; in_index = '0;
    repeat (3) step();
    chk("reset tx", tx4, 1);
    chk("reset busy", busy4, 0);
    chk("reset count", count4, 0);
    chk("reset in_ready", in_ready4, 0);
    rst_n = 1'b1;
    step();
    chk("in_ready after release", in_ready4, 1);
    chk("tx idle after release", tx4, 1);

    // Test-plan vector plus the table entries, each cycle-exact.
    send_exact("5A idx3", 8'h5A, 3'd3, 8'hA3, 8'h5A);
    for (int v = 0; v < 5; v++)
      send_exact($sformatf("vec%0d", v), vt[v].d, vt[v].ix, vt[v].hdr, vt[v].pay);

    // Back-to-back five pushes from idle.
    p = cyc + 1;
    fork
      begin
        for (int e = 0; e < 5; e++) begin
          in_data = vt[e].d; in_index = vt[e].ix; in_valid4 = 1'b1;
          chk($sformatf("b2b ready before push %0d", e), in_ready4, 1);
          step();
        end
        in_valid4 = 1'b0;
        chk("b2b count full", count4, 4);
        chk("b2b ready low when full", in_ready4, 0);
        while (cyc < p + 80) step();
        chk("b2b ready low at pop+79", in_ready4, 0);
        step();
        chk("b2b ready after 2nd pop", in_ready4, 1);
        chk("b2b count after 2nd pop", count4, 3);
      end
      begin
        logic [7:0] b;
        bit ok;
        int t0;
        for (int f = 0; f < 10; f++) begin
          rx_frame(1'b0, b, ok, t0);
          chk($sformatf("b2b framing %0d", f), ok, 1);
          chk($sformatf("b2b byte %0d", f), b, (f % 2 == 0) ? vt[f / 2].hdr : vt[f / 2].pay);
          chk($sformatf("b2b start time %0d", f), t0 - p, 1 + 40 * f);
        end
      end
    join
    repeat (4) step();
    chk("b2b busy at end", busy4, 0);

    // Full FIFO with in_valid held high over 12 entries (pointer wrap).
    run_stream("full", 1'b0, 12, 1'b0);

    // Simultaneous push and pop at fifo_count=2.
    p = cyc + 1;
    fork
      begin
        for (int e = 0; e < 3; e++) begin
          in_data = vt[e + 1].d; in_index = vt[e + 1].ix; in_valid4 = 1'b1;
          step();
        end
        in_valid4 = 1'b0;
        chk("pp count before", count4, 2);
        while (cyc < p + 80) step();
        chk("pp count at pop-1", count4, 2);
        in_data = 8'h77; in_index = 3'd5; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        chk("pp count after push+pop", count4, 2);
      end
      begin
        logic [7:0] b;
        bit ok;
        int t0;
        logic [7:0] ex [8];
        ex = '{8'hA7, 8'hC3, 8'hA1, 8'h00, 8'hA2, 8'hFF, 8'hA5, 8'h77};
        for (int f = 0; f < 8; f++) begin
          rx_frame(1'b0, b, ok, t0);
          chk($sformatf("pp framing %0d", f), ok, 1);
          chk($sformatf("pp byte %0d", f), b, ex[f]);
        end
      end
    join
    repeat (4) step();
    chk("pp busy at end", busy4, 0);

    // Reset for one cycle during the payload data bits, with one entry queued.
    p = cyc + 1;
    in_data = 8'h3C; in_index = 3'd6; in_valid4 = 1'b1;
    step();
    in_data = 8'h99; in_index = 3'd1;
    step();
    in_valid4 = 1'b0;
    while (cyc < p + 51) step();
    chk("mid-reset count before", count4, 1);
    rst_n = 1'b0;
    step();
    chk("mid-reset tx", tx4, 1);
    chk("mid-reset count", count4, 0);
    chk("mid-reset busy", busy4, 0);
    chk("mid-reset in_ready", in_ready4, 0);
    rst_n = 1'b1;
    step();
    chk("post-reset in_ready", in_ready4, 1);
    chk("post-reset busy", busy4, 0);
    send_exact("post-reset", 8'hE7, 3'd5, 8'hA5, 8'hE7);

    // Random entries at CLKS_PER_BIT=2, with random valid gaps.
    run_stream("rand2", 1'b1, 8, 1'b1);
    run_stream("rand4", 1'b0, 6, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
